// File: rtl/input_cond_pkg.sv
// Shared constants and types for the A/B/C input-conditioning stage.
// Channel indices name the gate-logic inputs carried on ui_in[2:0].
package input_cond_pkg;

  localparam int DEFAULT_STABLE_CYCLES = 4;

  localparam int CH_A = 0;
  localparam int CH_B = 1;
  localparam int CH_C = 2;

  typedef logic [$clog2(DEFAULT_STABLE_CYCLES+1)-1:0] cnt_t;

endpackage

// File: rtl/debounce_chan.sv
// One conditioned channel: two-flop synchroniser, stability counter, clean
// level flop and, when EDGE_EN is set, registered rise/fall pulse flops.
module debounce_chan
  import input_cond_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter bit RST_VAL       = 1'b0,
  parameter bit EDGE_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          clean_q, clean_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any sample that agrees with clean restarts the run, so short glitches vanish.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    cnt_d   = cnt_q;
    clean_d = clean_q;
    if (sync2_q != clean_q) begin
      if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
        clean_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so the sync chain shifts by one stage per edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      clean_q <= RST_VAL;
      cnt_q   <= '0;
    end else if (en) begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign clean = clean_q;

  if (EDGE_EN) begin : g_edge
    logic rise_q, fall_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= en && (clean_d != clean_q) &&  sync2_q;
        fall_q <= en && (clean_d != clean_q) && !sync2_q;
      end
    end

    assign rise = rise_q;
    assign fall = fall_q;
  end else begin : g_no_edge
    assign rise = 1'b0;
    assign fall = 1'b0;
  end

endmodule

// File: rtl/abc_input_conditioner.sv
// Conditions the A/B/C pad inputs: one debounce_chan per bit.
// Define INPUT_COND_EDGE_EN to build the rise/fall pulse flops; otherwise they read 0.
module abc_input_conditioner
  import input_cond_pkg::*;
#(
  parameter int               WIDTH         = 3,
  parameter int               STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter logic [WIDTH-1:0] RST_VAL       = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] clean,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

`ifdef INPUT_COND_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_chan #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .RST_VAL       (RST_VAL[i]),
      .EDGE_EN       (EDGE_EN)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .raw   (raw[i]),
      .clean (clean[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

endmodule

// File: tb/tb_abc_input_conditioner.sv
// Scoreboard bench for abc_input_conditioner: directed scenarios plus random
// stimulus, predicted by a run-length reference model of the debounce rules.
module tb_abc_input_conditioner;
  import input_cond_pkg::*;

  localparam int W  = 3;
  localparam int SC = 4;

`ifdef INPUT_COND_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b1;
  logic [W-1:0] raw = 3'b101;
  logic [W-1:0] clean, rise, fall;

  abc_input_conditioner #(
    .WIDTH         (W),
    .STABLE_CYCLES (SC),
    .RST_VAL       ('0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .raw   (raw),
    .clean (clean),
    .rise  (rise),
    .fall  (fall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: two sampled-cycle delay, then a count of consecutive
  // enabled edges on which the delayed sample disagreed with the clean level.
  int m_hist1[W];
  int m_hist2[W];
  int m_level[W];
  int m_run[W];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
    end
  endtask

  function automatic exp_t model_step(input logic [W-1:0] r, input logic e, input logic rs);
    exp_t x;
    x = '0;
    for (int c = 0; c < W; c++) begin
      if (rs) begin
        m_hist1[c] = 0;
        m_hist2[c] = 0;
        m_level[c] = 0;
        m_run[c]   = 0;
      end else if (e) begin
        if (m_hist2[c] != m_level[c]) begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == SC) begin
            m_level[c] = m_hist2[c];
            m_run[c]   = 0;
            if (m_level[c] == 1) x.rise[c] = EDGE;
            else                 x.fall[c] = EDGE;
          end
        end else begin
          m_run[c] = 0;
        end
        m_hist2[c] = m_hist1[c];
        m_hist1[c] = int'(r[c]);
      end
      x.clean[c] = (m_level[c] != 0);
    end
    return x;
  endfunction

  // Drive one cycle's inputs at the falling edge and queue the prediction
  // for the following rising edge.
  task automatic cycle(input logic [W-1:0] r, input logic e, input logic rs);
    @(negedge clk);
    raw = r;
    en  = e;
    rst = rs;
    exp_q.push_back(model_step(r, e, rs));
  endtask

  // Monitor: every rising edge the DUT presents a new output word.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("clean", clean, e.clean);
        check("rise",  rise,  e.rise);
        check("fall",  fall,  e.fall);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] r;
    int           len;
    logic [W-1:0] one_a;

    one_a = '0;
    one_a[CH_A] = 1'b1;

    // Reset held with raw=101, then release.
    repeat (3) cycle(3'b101, 1'b1, 1'b1);
    repeat (8) cycle(3'b101, 1'b1, 1'b0);

    // Return to 000, then a single step on A with an explicit latency probe.
    repeat (8) cycle(3'b000, 1'b1, 1'b0);
    cycle(one_a, 1'b1, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      cycle(one_a, 1'b1, 1'b0);
      check("latency_a", {2'b00, clean[CH_A]}, (i >= 6) ? 3'b001 : 3'b000);
    end
    repeat (2) cycle(one_a, 1'b1, 1'b0);

    // Glitch on B: three cycles high, then low.
    repeat (3) cycle(one_a | 3'b010, 1'b1, 1'b0);
    repeat (8) cycle(one_a, 1'b1, 1'b0);

    // Bounce for 10 cycles, then settle at 111.
    for (int i = 0; i < 10; i++) cycle((i % 2 == 0) ? 3'b000 : 3'b111, 1'b1, 1'b0);
    repeat (8) cycle(3'b111, 1'b1, 1'b0);

    // Reset mid-count on C after three mismatching edges.
    repeat (5) cycle(3'b011, 1'b1, 1'b0);
    cycle(3'b011, 1'b1, 1'b1);
    #1;
    check("async_rst_clean", clean, 3'b000);
    cycle(3'b111, 1'b1, 1'b1);
    repeat (8) cycle(3'b111, 1'b1, 1'b0);

    // Enable dropped mid-count for five cycles.
    repeat (3) cycle(3'b110, 1'b1, 1'b0);
    repeat (5) cycle(3'b110, 1'b0, 1'b0);
    repeat (8) cycle(3'b110, 1'b1, 1'b0);

    // Random segments: held levels, occasional enable drops and resets.
    for (int s = 0; s < 60; s++) begin
      r   = W'($urandom_range(0, 7));
      len = $urandom_range(1, 9);
      for (int k = 0; k < len; k++)
        cycle(r, ($urandom_range(0, 7) != 0), ($urandom_range(0, 99) == 0));
    end
    repeat (8) cycle(3'b000, 1'b1, 1'b0);

    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", W'(exp_q.size()), 3'b000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
